// File: rtl/cycle_sequencer_pkg.sv
// rtl/cycle_sequencer_pkg.sv - shared state, phase and opcode encodings for the cycle sequencer
package cycle_sequencer_pkg;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_FETCH = 3'd1,
    S_T0    = 3'd2,
    S_T1    = 3'd3,
    S_T2    = 3'd4,
    S_T3    = 3'd5,
    S_HALT  = 3'd6,
    S_ERR   = 3'd7
  } state_t;

  localparam logic [1:0] PH_0 = 2'b00;
  localparam logic [1:0] PH_1 = 2'b01;
  localparam logic [1:0] PH_2 = 2'b10;
  localparam logic [1:0] PH_3 = 2'b11;

  // Opcode field values, also decoded by the control logic.
  localparam logic [2:0] OP_ADD = 3'b000;
  localparam logic [2:0] OP_SUB = 3'b001;
  localparam logic [2:0] OP_NAN = 3'b010;
  localparam logic [2:0] OP_HLT = 3'b011;
  localparam logic [2:0] OP_OUT = 3'b100;
  localparam logic [2:0] OP_LDI = 3'b101;
  localparam logic [2:0] OP_BEZ = 3'b110;
  localparam logic [2:0] OP_REP = 3'b111;

  function automatic logic [1:0] phase_of(input state_t s);
    case (s)
      S_T0:    return PH_0;
      S_T1:    return PH_1;
      S_T2:    return PH_2;
      S_T3:    return PH_3;
      default: return PH_0;
    endcase
  endfunction

endpackage

// File: rtl/cycle_sequencer_edge_detect.sv
// rtl/cycle_sequencer_edge_detect.sv - rising-edge pulse generator for the single-step input
module edge_detect (
  input  logic clock,
  input  logic resetn,
  input  logic in,
  output logic rise
);

  logic q;

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) q <= 1'b0;
    else         q <= in;
  end

  assign rise = in & ~q;

endmodule

// File: rtl/cycle_sequencer.sv
// rtl/cycle_sequencer.sv - fetch handshake, phase counter and run/step/halt control for the multicycle core
module cycle_sequencer
  import cycle_sequencer_pkg::*;
#(
  parameter int IW       = 9,
  parameter int MAX_WAIT = 15,
  parameter int WAIT_W   = 8
) (
  input  logic          clock,
  input  logic          resetn,
  input  logic          run,
  input  logic          step,
  input  logic          mem_ack,
  input  logic [IW-1:0] mem_data,
  output logic          mem_req,
  output logic [IW-1:0] iin,
  output logic [1:0]    counter,
  output logic          phase_valid,
  output logic          busy,
  output logic          halted,
  output logic          timeout_err
);

  localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(MAX_WAIT - 1);

  state_t            state, next_state;
  logic [WAIT_W-1:0] wait_cnt, wait_nxt;
  logic              step_rise;
  logic [2:0]        opcode;

  logic          mem_req_d, busy_d, phase_valid_d, halted_d, timeout_d;
  logic [1:0]    counter_d;
  logic [IW-1:0] iin_d;

  assign opcode = iin[IW-1:IW-3];

  edge_detect u_step_edge (
    .clock  (clock),
    .resetn (resetn),
    .in     (step),
    .rise   (step_rise)
  );

  // Outputs are flopped from next-state decode so they line up with the state they describe.
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      state       <= S_IDLE;
      wait_cnt    <= '0;
      mem_req     <= 1'b0;
      busy        <= 1'b0;
      phase_valid <= 1'b0;
      halted      <= 1'b0;
      timeout_err <= 1'b0;
      counter     <= PH_0;
      iin         <= '0;
    end else begin
      state       <= next_state;
      wait_cnt    <= wait_nxt;
      mem_req     <= mem_req_d;
      busy        <= busy_d;
      phase_valid <= phase_valid_d;
      halted      <= halted_d;
      timeout_err <= timeout_d;
      counter     <= counter_d;
      iin         <= iin_d;
    end
  end

  always_comb begin
    next_state = state;
    wait_nxt   = '0;
    case (state)
      S_IDLE:  if (run || step_rise) next_state = S_FETCH;
      S_FETCH: begin
        if (mem_ack)                    next_state = S_T0;
        else if (wait_cnt == WAIT_LAST) next_state = S_ERR;
        else                            wait_nxt   = wait_cnt + WAIT_W'(1);
      end
      S_T0:    next_state = S_T1;
      S_T1:    next_state = (opcode == OP_HLT) ? S_HALT : S_T2;
      S_T2:    next_state = S_T3;
      S_T3:    next_state = run ? S_FETCH : S_IDLE;
      S_HALT:  next_state = S_HALT;
      S_ERR:   next_state = S_ERR;
      default: next_state = S_IDLE;
    endcase
  end

  always_comb begin
    mem_req_d     = 1'b0;
    busy_d        = 1'b0;
    phase_valid_d = 1'b0;
    halted_d      = 1'b0;
    timeout_d     = 1'b0;
    counter_d     = phase_of(next_state);
    iin_d         = iin;
    case (next_state)
      S_FETCH: begin
        mem_req_d = 1'b1;
        busy_d    = 1'b1;
      end
      S_T0, S_T1, S_T2, S_T3: begin
        busy_d        = 1'b1;
        phase_valid_d = 1'b1;
      end
      S_HALT:  halted_d  = 1'b1;
      S_ERR:   timeout_d = 1'b1;
      default: ;
    endcase
    if (state == S_FETCH && mem_ack) iin_d = mem_data;
  end

endmodule

// File: tb/tb_cycle_sequencer.sv
// tb/tb_cycle_sequencer.sv - self-checking bench for cycle_sequencer
module tb_cycle_sequencer;
  import cycle_sequencer_pkg::*;

  localparam int IW       = 9;
  localparam int MAX_WAIT = 15;
  localparam int WAIT_W   = 8;

  logic          clock = 1'b0;
  logic          resetn = 1'b0;
  logic          run = 1'b0;
  logic          step = 1'b0;
  logic          mem_ack = 1'b0;
  logic [IW-1:0] mem_data = '0;
  logic          mem_req, phase_valid, busy, halted, timeout_err;
  logic [IW-1:0] iin;
  logic [1:0]    counter;

  always #5 clock = ~clock;

  cycle_sequencer #(.IW(IW), .MAX_WAIT(MAX_WAIT), .WAIT_W(WAIT_W)) u_dut (
    .clock       (clock),
    .resetn      (resetn),
    .run         (run),
    .step        (step),
    .mem_ack     (mem_ack),
    .mem_data    (mem_data),
    .mem_req     (mem_req),
    .iin         (iin),
    .counter     (counter),
    .phase_valid (phase_valid),
    .busy        (busy),
    .halted      (halted),
    .timeout_err (timeout_err)
  );

  int n_cmp = 0;
  int n_bad = 0;

  logic [15:0] dut_obs;
  assign dut_obs = {mem_req, busy, phase_valid, halted, timeout_err, counter, iin};

  function automatic logic [15:0] obs(input logic req, input logic bsy, input logic pv,
                                      input logic h, input logic e, input logic [1:0] c,
                                      input logic [IW-1:0] w);
    return {req, bsy, pv, h, e, c, w};
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Instruction-level reference: idle / fetching / executing phase k / halted / errored.
  typedef enum int {M_IDLE, M_FETCH, M_EXEC, M_HALT, M_ERR} mmode_t;
  mmode_t        m_mode;
  int            m_ph;
  int            m_wait;
  logic [IW-1:0] m_iin;
  logic          m_step_q;

  task automatic model_reset();
    m_mode = M_IDLE; m_ph = 0; m_wait = 0; m_iin = '0; m_step_q = 1'b0;
  endtask

  task automatic model_clock();
    case (m_mode)
      M_IDLE: if (run || (step && !m_step_q)) begin m_mode = M_FETCH; m_wait = 0; end
      M_FETCH: begin
        if (mem_ack) begin m_iin = mem_data; m_mode = M_EXEC; m_ph = 0; end
        else if (m_wait == MAX_WAIT - 1) m_mode = M_ERR;
        else m_wait++;
      end
      M_EXEC: begin
        if (m_ph == 1 && m_iin[IW-1:IW-3] == OP_HLT) m_mode = M_HALT;
        else if (m_ph == 3) begin m_mode = run ? M_FETCH : M_IDLE; m_wait = 0; end
        else m_ph++;
      end
      default: ;
    endcase
    m_step_q = step;
  endtask

  function automatic logic [15:0] model_obs();
    return obs(m_mode == M_FETCH, m_mode == M_FETCH || m_mode == M_EXEC, m_mode == M_EXEC,
               m_mode == M_HALT, m_mode == M_ERR, (m_mode == M_EXEC) ? 2'(m_ph) : 2'b00, m_iin);
  endfunction

  task automatic tick();
    @(posedge clock);
    model_clock();
    #1;
    check("model", dut_obs, model_obs());
  endtask

  task automatic do_reset();
    #2;
    resetn = 1'b0; run = 1'b0; step = 1'b0; mem_ack = 1'b0;
    model_reset();
    #1;
    check("reset_values", dut_obs, 16'h0);
    @(posedge clock);
    #1;
    resetn = 1'b1;
  endtask

  typedef struct {
    logic          run;
    logic          step;
    logic          ack;
    logic [IW-1:0] data;
    logic [15:0]   exp;
  } vec_t;

  vec_t tbl [15];

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [IW-1:0] w_add, w_ldi;
    int req_n, pv_n, max_cnt, h_n;
    w_add = {OP_ADD, 6'b001_010};
    w_ldi = {OP_LDI, 6'b001_100};

    // Back-to-back ADD with 0-wait memory, then a 3-cycle ack delay, run dropped mid-instruction.
    tbl[0]  = '{1'b1, 1'b0, 1'b1, w_add, obs(1, 1, 0, 0, 0, 2'd0, 9'h000)};
    tbl[1]  = '{1'b1, 1'b0, 1'b1, w_add, obs(0, 1, 1, 0, 0, 2'd0, w_add)};
    tbl[2]  = '{1'b1, 1'b0, 1'b1, w_add, obs(0, 1, 1, 0, 0, 2'd1, w_add)};
    tbl[3]  = '{1'b1, 1'b0, 1'b1, w_add, obs(0, 1, 1, 0, 0, 2'd2, w_add)};
    tbl[4]  = '{1'b1, 1'b0, 1'b1, w_add, obs(0, 1, 1, 0, 0, 2'd3, w_add)};
    tbl[5]  = '{1'b1, 1'b0, 1'b0, w_ldi, obs(1, 1, 0, 0, 0, 2'd0, w_add)};
    tbl[6]  = '{1'b1, 1'b0, 1'b0, w_ldi, obs(1, 1, 0, 0, 0, 2'd0, w_add)};
    tbl[7]  = '{1'b1, 1'b0, 1'b0, w_ldi, obs(1, 1, 0, 0, 0, 2'd0, w_add)};
    tbl[8]  = '{1'b1, 1'b0, 1'b0, w_ldi, obs(1, 1, 0, 0, 0, 2'd0, w_add)};
    tbl[9]  = '{1'b0, 1'b0, 1'b1, w_ldi, obs(0, 1, 1, 0, 0, 2'd0, w_ldi)};
    tbl[10] = '{1'b0, 1'b0, 1'b0, 9'h000, obs(0, 1, 1, 0, 0, 2'd1, w_ldi)};
    tbl[11] = '{1'b0, 1'b0, 1'b0, 9'h000, obs(0, 1, 1, 0, 0, 2'd2, w_ldi)};
    tbl[12] = '{1'b0, 1'b0, 1'b0, 9'h000, obs(0, 1, 1, 0, 0, 2'd3, w_ldi)};
    tbl[13] = '{1'b0, 1'b0, 1'b0, 9'h000, obs(0, 0, 0, 0, 0, 2'd0, w_ldi)};
    tbl[14] = '{1'b0, 1'b0, 1'b1, 9'h1FF, obs(0, 0, 0, 0, 0, 2'd0, w_ldi)};

    model_reset();
    @(posedge clock);
    do_reset();
    for (int i = 0; i < 15; i++) begin
      run = tbl[i].run; step = tbl[i].step; mem_ack = tbl[i].ack; mem_data = tbl[i].data;
      tick();
      check($sformatf("vec%0d", i), dut_obs, tbl[i].exp);
    end

    // Single step of an OUT word; a second step edge during T2 must be discarded.
    do_reset();
    mem_ack = 1'b1; mem_data = {OP_OUT, 6'b011_000};
    req_n = 0; pv_n = 0;
    for (int i = 0; i < 12; i++) begin
      step = (i == 0 || i == 4);
      tick();
      if (mem_req) req_n++;
      if (phase_valid) pv_n++;
    end
    step = 1'b0;
    check("step_fetch_cycles", req_n, 1);
    check("step_phase_cycles", pv_n, 4);
    check("step_back_idle", busy, 1'b0);

    // HLT stops after T1 and ignores run/step until reset.
    do_reset();
    run = 1'b1; mem_ack = 1'b1; mem_data = {OP_HLT, 6'b000_000};
    pv_n = 0; max_cnt = 0;
    for (int i = 0; i < 8; i++) begin
      tick();
      if (phase_valid) pv_n++;
      if (int'(counter) > max_cnt) max_cnt = int'(counter);
    end
    check("hlt_phase_cycles", pv_n, 2);
    check("hlt_max_counter", max_cnt, 1);
    check("hlt_halted", {halted, phase_valid, mem_req}, 3'b100);
    h_n = 0;
    for (int i = 0; i < 6; i++) begin
      run = i[0]; step = i[1];
      tick();
      if (halted && !busy) h_n++;
    end
    check("hlt_sticky", h_n, 6);
    do_reset();
    check("hlt_cleared", halted, 1'b0);

    // Memory that never acknowledges.
    run = 1'b1; mem_ack = 1'b0;
    req_n = 0;
    for (int i = 0; i < 40 && !timeout_err; i++) begin
      tick();
      if (mem_req) req_n++;
    end
    check("timeout_seen", timeout_err, 1'b1);
    check("timeout_fetch_cycles", req_n, MAX_WAIT);
    mem_ack = 1'b1;
    for (int i = 0; i < 4; i++) tick();
    check("timeout_sticky", {timeout_err, mem_req, phase_valid}, 3'b100);

    // Asynchronous reset while in T2.
    do_reset();
    run = 1'b1; mem_ack = 1'b1; mem_data = {OP_SUB, 6'b010_001};
    for (int i = 0; i < 4; i++) tick();
    check("t2_counter", counter, 2'd2);
    #3;
    resetn = 1'b0;
    model_reset();
    #1;
    check("async_reset", dut_obs, 16'h0);
    run = 1'b0;
    @(posedge clock);
    #1;
    resetn = 1'b1;
    for (int i = 0; i < 3; i++) tick();
    check("idle_after_reset", dut_obs, 16'h0);

    // Randomised segments, each with its own memory-ack probability.
    for (int seg = 0; seg < 30; seg++) begin
      int ack_pct, run_pct, stuck;
      do_reset();
      ack_pct = (seg % 3 == 0) ? 5 : ((seg % 3 == 1) ? 50 : 95);
      run_pct = $urandom_range(10, 90);
      stuck = 0;
      for (int c = 0; c < 100 && stuck < 6; c++) begin
        run      = ($urandom_range(0, 99) < run_pct);
        step     = ($urandom_range(0, 99) < 30);
        mem_ack  = ($urandom_range(0, 99) < ack_pct);
        mem_data = IW'($urandom);
        tick();
        if (halted || timeout_err) stuck++;
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
